// File: rtl/router_fsm.sv
// Router packet-flow controller: decodes the header address, sequences
// payload writes into the selected FIFO, stalls on full/non-empty FIFOs and
// brackets each packet with parity load/check cycles.
//
// state | meaning
// DA    | decode address: wait for a valid header, latch destination
// LFD   | load first data: header byte written to FIFO, source held
// LD    | load data: payload bytes streamed to FIFO
// FFS   | fifo full: writes paused until the FIFO drains
// LAF   | load after full: write the byte held during the full stall
// LP    | load parity: parity byte written
// CPE   | check parity error: register block internal state cleared
// WTE   | wait till empty: destination FIFO still holds an older packet
module router_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_reg;
    logic       hdr_ok;
    logic       empty_hdr;
    logic       empty_addr;
    logic       soft_addr;

    // Select per-FIFO flags for the incoming header and the latched address
    always_comb begin
        hdr_ok     = pkt_valid && (data_in != 2'd3);
        empty_hdr  = 1'b0;
        empty_addr = 1'b0;
        soft_addr  = 1'b0;
        case (data_in)
            2'd0:    empty_hdr = fifo_empty_0;
            2'd1:    empty_hdr = fifo_empty_1;
            2'd2:    empty_hdr = fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
        case (addr_reg)
            2'd0: begin
                empty_addr = fifo_empty_0;
                soft_addr  = soft_reset_0;
            end
            2'd1: begin
                empty_addr = fifo_empty_1;
                soft_addr  = soft_reset_1;
            end
            2'd2: begin
                empty_addr = fifo_empty_2;
                soft_addr  = soft_reset_2;
            end
            default: begin
                empty_addr = 1'b0;
                soft_addr  = 1'b0;
            end
        endcase
    end

    // State register and destination address latch
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= DA;
            addr_reg <= 2'd0;
        end else begin
            state <= next_state;
            if (state == DA && hdr_ok)
                addr_reg <= data_in;
        end
    end

    // Next-state logic; a soft reset on the selected FIFO aborts the packet
    always_comb begin
        next_state = state;
        if (state != DA && soft_addr) begin
            next_state = DA;
        end else begin
            case (state)
                DA: begin
                    if (hdr_ok)
                        next_state = empty_hdr ? LFD : WTE;
                end
                WTE: begin
                    if (empty_addr)
                        next_state = LFD;
                end
                LFD: next_state = LD;
                LD: begin
                    if (fifo_full)
                        next_state = FFS;
                    else if (!pkt_valid)
                        next_state = LP;
                end
                FFS: begin
                    if (!fifo_full)
                        next_state = LAF;
                end
                LAF: begin
                    if (parity_done)
                        next_state = DA;
                    else if (low_pkt_valid)
                        next_state = LP;
                    else
                        next_state = LD;
                end
                LP:  next_state = CPE;
                CPE: next_state = fifo_full ? FFS : DA;
                default: next_state = DA;
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        detect_add    = (state == DA);
        lfd_state     = (state == LFD);
        ld_state      = (state == LD);
        full_state    = (state == FFS);
        laf_state     = (state == LAF);
        rst_int_reg   = (state == CPE);
        write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
        busy          = (state != DA) && (state != LD);
    end

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: walks each packet path and compares the
// full Moore output vector against hand-derived per-state values.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done, low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    int checks = 0;
    int errors = 0;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] O_DA  = 8'b1000_0000;
    localparam logic [7:0] O_LFD = 8'b0100_0001;
    localparam logic [7:0] O_LD  = 8'b0010_0100;
    localparam logic [7:0] O_LAF = 8'b0001_0101;
    localparam logic [7:0] O_FFS = 8'b0000_1001;
    localparam logic [7:0] O_LP  = 8'b0000_0101;
    localparam logic [7:0] O_CPE = 8'b0000_0011;
    localparam logic [7:0] O_WTE = 8'b0000_0001;

    wire [7:0] obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                      write_enb_reg, rst_int_reg, busy};

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
        .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; pkt_valid = 0; data_in = 0; fifo_full = 0;
        fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_pkt_valid = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL reset_state got %b want %b", obs, O_DA); end
        reset = 0;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL reset_idle got %b want %b", obs, O_DA); end
    endtask

    task automatic test_basic_packet();
        logic [7:0] exp_seq [7];
        exp_seq = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE};
        data_in = 2'd2; pkt_valid = 1; fifo_empty_2 = 1;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) pkt_valid = 0;
            tick();
            if (i == 1) data_in = 2'd0;
            checks++;
            if (obs !== exp_seq[i]) begin errors++; $display("FAIL basic_step%0d got %b want %b", i, obs, exp_seq[i]); end
        end
        fifo_empty_2 = 0;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL basic_return_da got %b want %b", obs, O_DA); end
    endtask

    task automatic test_fifo_full();
        logic [7:0] exp_seq [12];
        exp_seq = '{O_LFD, O_LD, O_FFS, O_FFS, O_LAF, O_LD, O_FFS, O_LAF, O_LP, O_CPE, O_FFS, O_LAF};
        data_in = 2'd0; pkt_valid = 1; fifo_empty_0 = 1;
        for (int i = 0; i < 12; i++) begin
            case (i)
                2:  fifo_full = 1;
                4:  fifo_full = 0;
                6:  fifo_full = 1;
                7:  fifo_full = 0;
                8:  begin low_pkt_valid = 1; pkt_valid = 0; end
                9:  begin low_pkt_valid = 0; fifo_full = 1; end
                10: fifo_full = 1;
                11: fifo_full = 0;
                default: ;
            endcase
            tick();
            checks++;
            if (obs !== exp_seq[i]) begin errors++; $display("FAIL full_step%0d got %b want %b", i, obs, exp_seq[i]); end
        end
        parity_done = 1;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL laf_parity_done got %b want %b", obs, O_DA); end
        parity_done = 0; fifo_empty_0 = 0;
    endtask

    task automatic test_wait_till_empty();
        data_in = 2'd1; pkt_valid = 1; fifo_empty_1 = 0;
        tick();
        checks++;
        if (obs !== O_WTE) begin errors++; $display("FAIL wte_enter got %b want %b", obs, O_WTE); end
        data_in = 2'd0; fifo_empty_0 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== O_WTE) begin errors++; $display("FAIL wte_hold%0d got %b want %b", i, obs, O_WTE); end
        end
        fifo_empty_1 = 1;
        tick();
        checks++;
        if (obs !== O_LFD) begin errors++; $display("FAIL wte_to_lfd got %b want %b", obs, O_LFD); end
        pkt_valid = 0;
        tick(); tick(); tick(); tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL wte_pkt_done got %b want %b", obs, O_DA); end
        fifo_empty_0 = 0; fifo_empty_1 = 0;
    endtask

    task automatic test_addr3();
        data_in = 2'd3; pkt_valid = 1;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== O_DA) begin errors++; $display("FAIL addr3_hold%0d got %b want %b", i, obs, O_DA); end
        end
        pkt_valid = 0;
        fifo_empty_0 = 0; fifo_empty_1 = 0; fifo_empty_2 = 0;
    endtask

    task automatic test_soft_reset();
        data_in = 2'd0; pkt_valid = 1; fifo_empty_0 = 1;
        tick(); tick();
        checks++;
        if (obs !== O_LD) begin errors++; $display("FAIL soft_setup_ld got %b want %b", obs, O_LD); end
        soft_reset_1 = 1; soft_reset_2 = 1;
        tick();
        checks++;
        if (obs !== O_LD) begin errors++; $display("FAIL soft_other_fifo got %b want %b", obs, O_LD); end
        soft_reset_1 = 0; soft_reset_2 = 0; soft_reset_0 = 1;
        pkt_valid = 0;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL soft_sel_fifo got %b want %b", obs, O_DA); end
        soft_reset_0 = 0; fifo_empty_0 = 0;
        data_in = 2'd2; pkt_valid = 1; fifo_empty_2 = 0;
        tick();
        checks++;
        if (obs !== O_WTE) begin errors++; $display("FAIL soft_wte_enter got %b want %b", obs, O_WTE); end
        soft_reset_2 = 1; pkt_valid = 0;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL soft_wte_abort got %b want %b", obs, O_DA); end
        soft_reset_2 = 0;
    endtask

    task automatic test_reset_mid_packet();
        data_in = 2'd1; pkt_valid = 1; fifo_empty_1 = 1;
        tick(); tick();
        fifo_full = 1;
        tick();
        checks++;
        if (obs !== O_FFS) begin errors++; $display("FAIL midrst_ffs got %b want %b", obs, O_FFS); end
        reset = 1; soft_reset_1 = 1;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL midrst_da got %b want %b", obs, O_DA); end
        reset = 0; soft_reset_1 = 0; fifo_full = 0; pkt_valid = 0; fifo_empty_1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== O_DA) begin errors++; $display("FAIL midrst_no_write%0d got %b want %b", i, obs, O_DA); end
        end
    endtask

    task automatic test_back_to_back();
        // Second header presented in the DA cycle right after CPE.
        data_in = 2'd2; pkt_valid = 1; fifo_empty_2 = 1;
        tick(); tick();
        pkt_valid = 0;
        tick(); tick();
        checks++;
        if (obs !== O_CPE) begin errors++; $display("FAIL b2b_cpe got %b want %b", obs, O_CPE); end
        data_in = 2'd0; pkt_valid = 1; fifo_empty_0 = 0;
        tick();
        checks++;
        if (obs !== O_DA) begin errors++; $display("FAIL b2b_da got %b want %b", obs, O_DA); end
        tick();
        checks++;
        if (obs !== O_WTE) begin errors++; $display("FAIL b2b_wte got %b want %b", obs, O_WTE); end
        fifo_empty_0 = 1;
        tick();
        checks++;
        if (obs !== O_LFD) begin errors++; $display("FAIL b2b_lfd got %b want %b", obs, O_LFD); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_packet();
        test_fifo_full();
        test_wait_till_empty();
        test_addr3();
        test_soft_reset();
        test_reset_mid_packet();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
